// File: rtl/adc_req_scheduler.sv
// adc_req_scheduler: round-robin owner of the shared ADS8864 engine and mux.
// Grants bursts, settles the mux, fires conversions, routes samples back.
module adc_req_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SEL_W          = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_sd,
    input  logic                  OPB_RST,
    input  logic                  ENABLE,
    input  logic [NUM_REQ-1:0]    REQ,
    input  logic [12*NUM_REQ-1:0] REQ_LEN,
    output logic [NUM_REQ-1:0]    GNT,
    output logic [SEL_W-1:0]      MUX_SEL,
    output logic                  CONV_START,
    input  logic                  CONV_DONE,
    input  logic [15:0]           CONV_DATA,
    output logic [15:0]           SMP_DATA,
    output logic [NUM_REQ-1:0]    SMP_VALID,
    output logic [NUM_REQ-1:0]    DONE,
    output logic                  ERR,
    output logic                  BUSY
);

    localparam int SMAX = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int STW  = $clog2(SMAX + 1);
    localparam int TMAX = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int TOW  = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_q, rr_d;
    logic [11:0]        len_q, len_d;
    logic [11:0]        cnt_q, cnt_d;
    logic [STW-1:0]     stl_q, stl_d;
    logic [TOW-1:0]     tmo_q, tmo_d;
    logic               start_q, start_d;
    logic [15:0]        data_q, data_d;
    logic [NUM_REQ-1:0] vld_q, vld_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               win_ok;
    logic [SEL_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [11:0]        win_len;
    logic [NUM_REQ-1:0] req_sh;
    logic [12*NUM_REQ-1:0] len_sh;
    int                 win_j;
    logic [11:0]        cnt_inc;
    logic               own_req;

    assign cnt_inc = cnt_q + 12'd1;
    assign own_req = |(REQ & gnt_q);

    // Pick the first requester after rr_q, wrapping around the index range.
    always_comb begin
        win_ok  = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        win_len = '0;
        req_sh  = '0;
        len_sh  = '0;
        win_j   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            win_j = int'(rr_q) + i;
            if (win_j >= NUM_REQ) begin
                win_j = win_j - NUM_REQ;
            end
            req_sh = REQ >> win_j;
            len_sh = REQ_LEN >> (12 * win_j);
            if (!win_ok && req_sh[0]) begin
                win_ok  = 1'b1;
                win_idx = SEL_W'(win_j);
                win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_j;
                win_len = len_sh[11:0];
            end
        end
    end

    // Next-state and registered-output decode for the burst sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        stl_d   = stl_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        start_d = 1'b0;
        vld_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ENABLE && win_ok) begin
                    state_d = S_SETTLE;
                    gnt_d   = win_oh;
                    sel_d   = win_idx;
                    rr_d    = win_idx;
                    cnt_d   = '0;
                    stl_d   = '0;
                    len_d   = (win_len == 12'd0) ? 12'd1 : win_len;
                end
            end
            S_SETTLE: begin
                if (stl_q == STW'(SMAX - 1)) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    stl_d = stl_q + 1'b1;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (CONV_DONE) begin
                    state_d = S_DELIVER;
                    data_d  = CONV_DATA;
                    vld_d   = gnt_q;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        done_d = gnt_q;
                    end
                end else if (tmo_q == TOW'(TMAX - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DELIVER: begin
                if (cnt_q == len_q) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (ENABLE && own_req) begin
                    state_d = S_START;
                    start_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; OPB_RST clears everything at once.
    always_ff @(posedge clk_sd or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= SEL_W'(NUM_REQ - 1);
            len_q   <= 12'd1;
            cnt_q   <= '0;
            stl_q   <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            vld_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            stl_q   <= stl_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT        = gnt_q;
    assign MUX_SEL    = sel_q;
    assign CONV_START = start_q;
    assign SMP_DATA   = data_q;
    assign SMP_VALID  = vld_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_adc_req_scheduler.sv
// Directed bench for adc_req_scheduler: bursts, round robin, zero length,
// timeout, early release and reset during a returning conversion.
module tb_adc_req_scheduler;

    localparam int N = 4;

    logic            clk_sd    = 1'b0;
    logic            OPB_RST   = 1'b1;
    logic            ENABLE    = 1'b1;
    logic [N-1:0]    REQ       = '0;
    logic [12*N-1:0] REQ_LEN   = '0;
    logic            CONV_DONE = 1'b0;
    logic [15:0]     CONV_DATA = '0;
    logic [N-1:0]    GNT;
    logic [1:0]      MUX_SEL;
    logic            CONV_START;
    logic [15:0]     SMP_DATA;
    logic [N-1:0]    SMP_VALID;
    logic [N-1:0]    DONE;
    logic            ERR;
    logic            BUSY;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int cd    = 0;
    int eng_n = 0;
    bit eng_en = 1'b1;
    int bad_sel  = 0;
    int bad_busy = 0;
    logic [N-1:0] gnt_prev = '0;

    int           st_q[$];
    int           sv_q[$];
    logic [15:0]  sd_q[$];
    logic [N-1:0] sm_q[$];
    int           dn_q[$];
    logic [N-1:0] dm_q[$];
    int           er_q[$];
    int           gc_q[$];
    logic [N-1:0] gl_q[$];

    adc_req_scheduler #(
        .NUM_REQ(4),
        .SEL_W(2),
        .SETTLE_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_sd(clk_sd),
        .OPB_RST(OPB_RST),
        .ENABLE(ENABLE),
        .REQ(REQ),
        .REQ_LEN(REQ_LEN),
        .GNT(GNT),
        .MUX_SEL(MUX_SEL),
        .CONV_START(CONV_START),
        .CONV_DONE(CONV_DONE),
        .CONV_DATA(CONV_DATA),
        .SMP_DATA(SMP_DATA),
        .SMP_VALID(SMP_VALID),
        .DONE(DONE),
        .ERR(ERR),
        .BUSY(BUSY)
    );

    initial forever #5 clk_sd = ~clk_sd;

    always @(posedge clk_sd) cyc <= cyc + 1;

    // Engine model: answers 5 cycles after each CONV_START with A000+n.
    always @(negedge clk_sd) begin
        CONV_DONE <= 1'b0;
        if (cd > 0) begin
            if (cd == 1) begin
                CONV_DONE <= 1'b1;
                CONV_DATA <= 16'hA000 + 16'(eng_n + 1);
                eng_n     <= eng_n + 1;
            end
            cd <= cd - 1;
        end
        if (CONV_START && eng_en) cd <= 5;
    end

    // Event recorder, sampled on the falling edge.
    always @(negedge clk_sd) begin
        if (CONV_START) st_q.push_back(cyc);
        if (|SMP_VALID) begin
            sv_q.push_back(cyc);
            sd_q.push_back(SMP_DATA);
            sm_q.push_back(SMP_VALID);
        end
        if (|DONE) begin
            dn_q.push_back(cyc);
            dm_q.push_back(DONE);
        end
        if (ERR) er_q.push_back(cyc);
        if (GNT != gnt_prev) begin
            gl_q.push_back(GNT);
            gc_q.push_back(cyc);
        end
        gnt_prev <= GNT;
        if (GNT != '0 && GNT != (4'b0001 << MUX_SEL)) bad_sel <= bad_sel + 1;
        if ((GNT != '0) != BUSY) bad_busy <= bad_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_len(input int idx, input logic [11:0] v);
        REQ_LEN[12*idx +: 12] = v;
    endtask

    task automatic wait_ev(input int sel, input int budget, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk_sd);
            #1;
            case (sel)
                0:       hit = |DONE;
                1:       hit = ERR;
                2:       hit = |SMP_VALID;
                default: hit = CONV_DONE;
            endcase
        end
        chk(tag, 32'(hit), 1);
    endtask

    task automatic get_gnt(input int base, input int k,
                           output logic [N-1:0] g, output int c);
        int n = 0;
        g = '0;
        c = -1;
        for (int i = base; i < gl_q.size(); i++) begin
            if (gl_q[i] != '0) begin
                if (n == k) begin
                    g = gl_q[i];
                    c = gc_q[i];
                end
                n++;
            end
        end
    endtask

    initial begin
        int sb, db, gb, stb, eb, gcy;
        logic [N-1:0] g;
        logic [N-1:0] ord [5];
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (2) @(negedge clk_sd);
        #1;
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_misc", 32'({MUX_SEL, CONV_START, SMP_DATA, SMP_VALID, DONE, ERR}), 0);
        OPB_RST = 1'b0;

        ENABLE = 1'b0;
        REQ    = 4'b0001;
        set_len(0, 12'd3);
        repeat (10) @(negedge clk_sd);
        #1;
        chk("en_block", 32'({BUSY, GNT}), 0);

        gb = gl_q.size(); stb = st_q.size(); sb = sv_q.size(); db = dn_q.size();
        ENABLE = 1'b1;
        wait_ev(0, 100, "s1_done_seen");
        REQ = '0;
        get_gnt(gb, 0, g, gcy);
        chk("s1_gnt", 32'(g), 4'b0001);
        chk("s1_nstart", st_q.size() - stb, 3);
        chk("s1_nsmp", sv_q.size() - sb, 3);
        chk("s1_settle", st_q[stb] - gcy, 8);
        chk("s1_gap", st_q[stb+1] - st_q[stb], 7);
        chk("s1_lat", sv_q[sb] - st_q[stb], 6);
        for (int k = 0; k < 3; k++) begin
            chk("s1_data", 32'(sd_q[sb+k]), 32'h0000_A001 + k);
            chk("s1_vmask", 32'(sm_q[sb+k]), 4'b0001);
        end
        chk("s1_done_cyc", dn_q[db] - sv_q[sb+2], 0);
        chk("s1_done_mask", 32'(dm_q[db]), 4'b0001);
        @(negedge clk_sd);
        #1;
        chk("s1_busy_fall", 32'({BUSY, GNT}), 0);

        OPB_RST = 1'b1;
        @(negedge clk_sd);
        #1;
        OPB_RST = 1'b0;
        for (int i = 0; i < N; i++) set_len(i, 12'd1);
        gb = gl_q.size(); stb = st_q.size(); db = dn_q.size();
        REQ = 4'b1111;
        repeat (5) wait_ev(0, 60, "s2_done_seen");
        REQ = '0;
        for (int k = 0; k < 5; k++) begin
            get_gnt(gb, k, g, gcy);
            chk("s2_order", 32'(g), 32'(ord[k]));
            chk("s2_settle", st_q[stb+k] - gcy, 8);
            chk("s2_done", 32'(dm_q[db+k]), 32'(ord[k]));
        end
        chk("s2_release", gc_q[gb+1] - gc_q[gb], 15);
        chk("s2_regrant", gc_q[gb+2] - gc_q[gb+1], 1);
        repeat (3) @(negedge clk_sd);
        #1;

        set_len(2, 12'd0);
        sb = sv_q.size(); db = dn_q.size();
        REQ = 4'b0100;
        wait_ev(0, 60, "s3_done_seen");
        REQ = '0;
        repeat (20) @(negedge clk_sd);
        #1;
        chk("s3_nsmp", sv_q.size() - sb, 1);
        chk("s3_ndone", dn_q.size() - db, 1);
        chk("s3_vmask", 32'(sm_q[sb]), 4'b0100);
        chk("s3_done", 32'(dm_q[db]), 4'b0100);

        eng_en = 1'b0;
        set_len(1, 12'd1);
        eb = er_q.size(); sb = sv_q.size(); db = dn_q.size(); stb = st_q.size();
        REQ = 4'b0010;
        wait_ev(1, 150, "s4_err_seen");
        chk("s4_err_lat", er_q[eb] - st_q[stb], 65);
        chk("s4_gnt_drop", 32'(GNT), 0);
        chk("s4_nsmp", sv_q.size() - sb, 0);
        chk("s4_ndone", dn_q.size() - db, 0);
        eng_en = 1'b1;
        @(negedge clk_sd);
        #1;
        chk("s4_err_pulse", 32'(ERR), 0);
        wait_ev(0, 60, "s4_retry_seen");
        REQ = '0;
        chk("s4_retry", 32'(dm_q[db]), 4'b0010);
        chk("s4_nerr", er_q.size() - eb, 1);
        repeat (3) @(negedge clk_sd);
        #1;

        set_len(1, 12'd10);
        sb = sv_q.size(); db = dn_q.size();
        REQ = 4'b0010;
        wait_ev(2, 60, "s5_smp1");
        wait_ev(2, 20, "s5_smp2");
        @(negedge clk_sd);
        #1;
        REQ = '0;
        wait_ev(2, 20, "s5_smp3");
        @(negedge clk_sd);
        #1;
        chk("s5_release", 32'({BUSY, GNT}), 0);
        repeat (20) @(negedge clk_sd);
        #1;
        chk("s5_nsmp", sv_q.size() - sb, 3);
        chk("s5_ndone", dn_q.size() - db, 0);
        chk("s5_vmask", 32'(sm_q[sb+2]), 4'b0010);

        set_len(1, 12'd2);
        set_len(0, 12'd1);
        set_len(2, 12'd1);
        sb = sv_q.size();
        REQ = 4'b0010;
        wait_ev(3, 60, "s6_cdone_seen");
        OPB_RST = 1'b1;
        REQ     = 4'b0101;
        #1;
        chk("s6_rst_gnt", 32'(GNT), 0);
        chk("s6_rst_busy", 32'(BUSY), 0);
        chk("s6_rst_data", 32'(SMP_DATA), 0);
        chk("s6_rst_misc", 32'({MUX_SEL, CONV_START, SMP_VALID, DONE, ERR}), 0);
        @(negedge clk_sd);
        #1;
        chk("s6_no_smp", sv_q.size() - sb, 0);
        gb = gl_q.size(); db = dn_q.size();
        OPB_RST = 1'b0;
        wait_ev(0, 60, "s6_done_seen");
        REQ = '0;
        get_gnt(gb, 0, g, gcy);
        chk("s6_first", 32'(g), 4'b0001);
        chk("s6_done", 32'(dm_q[db]), 4'b0001);
        repeat (5) @(negedge clk_sd);
        #1;
        chk("mux_track", bad_sel, 0);
        chk("busy_track", bad_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
